// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative HI/LO multiply/divide unit for the execute stage
module execute_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_StartE,
    input  logic                  i_FlushE,
    input  logic [2:0]            i_MDOpE,
    input  logic [DATA_WIDTH-1:0] i_SrcAE,
    input  logic [DATA_WIDTH-1:0] i_SrcBE,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO,
    output logic                  o_BusyE
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [W-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [W-1:0]       op_a_q, op_a_d, op_b_q, op_b_d, raw_a_q, raw_a_d;
    logic               div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic               op_valid, accept, is_signed, is_div_op, a_neg, b_neg;
    logic [W-1:0]       mag_a, mag_b;
    logic [W:0]         mul_sum, rem_sh, diff;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quot_fix, rem_fix;

    assign op_valid  = (i_MDOpE != 3'd0) && (i_MDOpE != 3'd7);
    assign accept    = (state_q == S_IDLE) && i_StartE && !i_FlushE && op_valid;
    assign is_signed = (i_MDOpE == 3'd1) || (i_MDOpE == 3'd3);
    assign is_div_op = (i_MDOpE == 3'd3) || (i_MDOpE == 3'd4);
    assign a_neg     = is_signed && i_SrcAE[W-1];
    assign b_neg     = is_signed && i_SrcBE[W-1];
    assign mag_a     = a_neg ? -i_SrcAE : i_SrcAE;
    assign mag_b     = b_neg ? -i_SrcBE : i_SrcBE;

    // Multiply: add into the high half, shift right; product bits settle into the low half.
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (op_b_q[0] ? {1'b0, op_a_q} : {(W+1){1'b0}});
    // Divide: remainder lives in acc high half, quotient bits shift into the low half.
    assign rem_sh    = {acc_q[2*W-1:W], op_a_q[W-1]};
    assign diff      = rem_sh - {1'b0, op_b_q};

    assign prod_fix  = neg_q ? -acc_q : acc_q;
    assign quot_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix   = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        raw_a_d   = raw_a_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (i_MDOpE == 3'd5) begin
                        hi_d = i_SrcAE;
                    end else if (i_MDOpE == 3'd6) begin
                        lo_d = i_SrcAE;
                    end else begin
                        op_a_d    = mag_a;
                        op_b_d    = mag_b;
                        raw_a_d   = i_SrcAE;
                        div_d     = is_div_op;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        dz_d      = (i_SrcBE == '0);
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (div_q) begin
                    acc_d  = {(diff[W] ? rem_sh[W-1:0] : diff[W-1:0]), acc_q[W-2:0], ~diff[W]};
                    op_a_d = op_a_q << 1;
                end else begin
                    acc_d  = {mul_sum, acc_q[W-1:1]};
                    op_b_d = op_b_q >> 1;
                end
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            raw_a_q   <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            raw_a_q   <= raw_a_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign o_HI    = hi_q;
    assign o_LO    = lo_q;
    assign o_BusyE = busy_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb/tb_execute_muldiv_unit.sv - scoreboard bench for execute_muldiv_unit
module tb_execute_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy;

    execute_muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .i_CLK(clk), .i_RST(rst), .i_StartE(start), .i_FlushE(flush),
        .i_MDOpE(op), .i_SrcAE(a), .i_SrcBE(b),
        .o_HI(hi), .o_LO(lo), .o_BusyE(busy)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    logic [63:0] now_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    // Reference: {HI,LO} from plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] cur);
        longint sx, sy, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd1: begin u = 64'(sx * sy); return u; end
            3'd2: begin u = {32'b0, x} * {32'b0, y}; return u; end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            3'd5: return {x, cur[31:0]};
            3'd6: return {cur[63:32], x};
            default: return cur;
        endcase
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
        @(posedge clk); #1;
        m_hi = '0; m_lo = '0;
        now_q.push_back(64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic fl, input logic st);
        logic        acc;
        logic [63:0] r;
        @(posedge clk); #1;
        start = st; flush = fl; op = o; a = x; b = y;
        acc = st && !fl && (o != 3'd0) && (o != 3'd7);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        if (acc) begin
            r = ref_res(o, x, y, {m_hi, m_lo});
            {m_hi, m_lo} = r;
            if (o == 3'd5 || o == 3'd6) begin
                now_q.push_back(r);
            end else begin
                exp_q.push_back(r);
                wait_idle();
            end
        end else begin
            now_q.push_back({m_hi, m_lo});
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    // Monitor: pops expectations when a busy period ends or an immediate check is queued.
    initial begin
        logic [63:0] r;
        logic        busy_prev;
        int          busy_cnt;
        int          cycles;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        cycles    = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (now_q.size() > 0) begin
                r = now_q.pop_front();
                chk("now_hi", hi, r[63:32]);
                chk("now_lo", lo, r[31:0]);
                chk("now_busy", {31'b0, busy}, 32'd0);
            end
            if (rst) begin
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
                if (busy_cnt == 45) chk("busy_timeout", busy_cnt, 32'd33);
            end else if (busy_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("busy_len", busy_cnt, 32'd33);
                    chk("res_hi", hi, r[63:32]);
                    chk("res_lo", lo, r[31:0]);
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
            if (done || cycles > 50000) begin
                if (cycles > 50000) chk("global_timeout", cycles, 32'd50000);
                chk("pending_results", exp_q.size(), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] r;
        do_reset();
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        issue(3'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        issue(3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
        issue(3'd4, 32'h55, 32'd0, 1'b0, 1'b1);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(3'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1);

        // Start pulse while running must be ignored.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        r = ref_res(3'd1, 32'd5, 32'd6, {m_hi, m_lo});
        {m_hi, m_lo} = r;
        exp_q.push_back(r);
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        wait_idle();

        issue(3'd1, 32'd9, 32'd9, 1'b1, 1'b1);
        issue(3'd7, 32'd9, 32'd9, 1'b0, 1'b1);
        issue(3'd0, 32'd9, 32'd9, 1'b0, 1'b1);
        issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (8) @(posedge clk);
        do_reset();
        issue(3'd1, 32'd2, 32'd3, 1'b0, 1'b1);

        repeat (40) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            issue(ro, ra, rb, ($urandom_range(0, 9) == 0), 1'b1);
        end
        @(posedge clk);
        done = 1'b1;
    end
endmodule
